// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: opcode encodings,
// controller state encoding and the iteration count.
package mips_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit writing the HI/LO pair.
// One shift-add or restoring-divide step per cycle; sign handling is done on magnitudes.
module mult_div_unit
    import mips_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

    md_state_e   r_state;
    md_state_e   w_next_state;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [5:0]  r_cnt;
    logic [1:0]  r_opc;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed_in;
    logic [31:0] w_a_in;
    logic [31:0] w_b_in;
    logic [32:0] w_mul_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Controller: state register plus next-state logic.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next_state = ST_CALC;
            ST_CALC: if (r_cnt == 6'(MD_ITER - 1)) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_signed_in = ~op[0];
    assign w_a_in      = w_signed_in ? abs32(rs_val) : rs_val;
    assign w_b_in      = w_signed_in ? abs32(rt_val) : rt_val;

    // Multiply keeps the multiplier in the low half and shifts the product in from the top.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    // Divide shifts the dividend out of the low half into the partial remainder;
    // the remainder stays below the divisor, so 33 bits cover the shifted value.
    assign w_rem_sh  = r_acc[63:31];
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};

    always_comb begin
        if (r_opc[1]) begin
            if (w_diff[32]) begin
                w_step = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
            end else begin
                w_step = {w_diff[31:0], r_acc[30:0], 1'b1};
            end
        end else begin
            w_step = {w_mul_sum, r_acc[31:1]};
        end
    end

    // A zero divisor leaves |dividend| as remainder, so re-signing it restores rs_val.
    assign w_prod = r_neg_q ? neg64(r_acc) : r_acc;
    assign w_quot = (r_opnd == 32'd0) ? 32'hFFFF_FFFF
                  : (r_neg_q ? neg32(r_acc[31:0]) : r_acc[31:0]);
    assign w_rem  = r_neg_r ? neg32(r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc   <= 64'd0;
            r_opnd  <= 32'd0;
            r_cnt   <= 6'd0;
            r_opc   <= 2'b00;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opc   <= op;
                        r_cnt   <= 6'd0;
                        r_neg_q <= w_signed_in & (rs_val[31] ^ rt_val[31]);
                        r_neg_r <= w_signed_in & rs_val[31];
                        if (op[1]) begin
                            r_opnd <= w_b_in;
                            r_acc  <= {32'd0, w_a_in};
                        end else begin
                            r_opnd <= w_a_in;
                            r_acc  <= {32'd0, w_b_in};
                        end
                    end else begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 6'd1;
                end
                ST_FIX: begin
                    r_done <= 1'b1;
                    if (r_opc[1]) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
